mem_port_arbiter: RTL and testbench

Arbitrates the data port (port B) of the dual-port `memory` between two requesters: the CPU data path (loads, stores, stack pushes and pops from `CPU_Wrapper1`) and an external requester (program loader or debug access). It holds ownership across bursts, rotates fairly with a bounded burst length, and returns synchronous read data with a matching valid strobe. While the CPU is not granted, the block stalls it. Port A (instruction fetch) is not touched.

---
 rtl/mem_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the data port (port B) of the dual-port memory between the CPU data
// path and an external requester (program loader / debug access). Ownership
// is held across bursts. An owner is forced to yield after MAX_BURST beats,
// but only while the other requester is waiting. Read data from the
// synchronous memory is passed straight through. A per-requester valid strobe
// marks the cycle after each read beat. Port A (instruction fetch) is not
// handled here.
//
// Parameters:
//   AW            address width
//   DW            data width
//   MAX_BURST     beats an owner may take before yielding to a waiting
//                 requester (1..15)
//   CPU_PRIORITY  1: CPU wins every tie from IDLE; 0: ties alternate
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU beat request, held until granted
//   cpu_gnt, cpu_stall, cpu_rvalid CPU grant, stall (req & ~gnt), read valid
//   ext_req/we/addr/wdata          external beat request, held until granted
//   ext_gnt, ext_rvalid            external grant, read valid
//   rdata                          memory read data, shared by both requesters
//   mem_we_b, mem_addr_b,
//   mem_write_data_b               port B controls, driven by the granted side
//   mem_data_out_b                 port B read data (1-cycle latency)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 8,
    parameter int DW           = 8,
    parameter int MAX_BURST    = 4,
    parameter int CPU_PRIORITY = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,

    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,

    output logic [DW-1:0] rdata,

    output logic          mem_we_b,
    output logic [AW-1:0] mem_addr_b,
    output logic [DW-1:0] mem_write_data_b,
    input  logic [DW-1:0] mem_data_out_b
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_EXT = 2'd2
    } state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
    localparam logic       OWNER_CPU   = 1'b0;
    localparam logic       OWNER_EXT   = 1'b1;

    state_t     state;
    logic [3:0] beat_cnt;
    logic       last_owner;
    logic       rd_pend_cpu;
    logic       rd_pend_ext;
    logic       burst_left;

    // An owner keeps getting beats past the limit as long as nobody else
    // is waiting; the limit only matters when the other side wants the port.
    assign burst_left = (beat_cnt < BURST_LIMIT);

    assign cpu_gnt   = (state == OWN_CPU) && cpu_req && (burst_left || !ext_req);
    assign ext_gnt   = (state == OWN_EXT) && ext_req && (burst_left || !cpu_req);
    assign cpu_stall = cpu_req && !cpu_gnt;

    assign cpu_rvalid = rd_pend_cpu;
    assign ext_rvalid = rd_pend_ext;
    assign rdata      = mem_data_out_b;

    // Port B is driven only by a granted requester; otherwise it is parked at
    // zero so no stray write can reach the memory.
    always_comb begin
        mem_we_b         = 1'b0;
        mem_addr_b       = '0;
        mem_write_data_b = '0;
        if (cpu_gnt) begin
            mem_we_b         = cpu_we;
            mem_addr_b       = cpu_addr;
            mem_write_data_b = cpu_wdata;
        end else if (ext_gnt) begin
            mem_we_b         = ext_we;
            mem_addr_b       = ext_addr;
            mem_write_data_b = ext_wdata;
        end
    end

    // Ownership FSM, burst counter and read-pending flags. Entering an owner
    // state always restarts the burst count and records who owns the port,
    // so a tie from IDLE can go to the side that did not own it last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= 4'd0;
            last_owner  <= OWNER_EXT;
            rd_pend_cpu <= 1'b0;
            rd_pend_ext <= 1'b0;
        end else begin
            rd_pend_cpu <= cpu_gnt && !cpu_we;
            rd_pend_ext <= ext_gnt && !ext_we;

            case (state)
                IDLE: begin
                    if (cpu_req && ext_req) begin
                        if ((CPU_PRIORITY != 0) || (last_owner == OWNER_EXT)) begin
                            state      <= OWN_CPU;
                            beat_cnt   <= 4'd0;
                            last_owner <= OWNER_CPU;
                        end else begin
                            state      <= OWN_EXT;
                            beat_cnt   <= 4'd0;
                            last_owner <= OWNER_EXT;
                        end
                    end else if (cpu_req) begin
                        state      <= OWN_CPU;
                        beat_cnt   <= 4'd0;
                        last_owner <= OWNER_CPU;
                    end else if (ext_req) begin
                        state      <= OWN_EXT;
                        beat_cnt   <= 4'd0;
                        last_owner <= OWNER_EXT;
                    end
                end

                OWN_CPU: begin
                    // Hand over directly when the other side is waiting,
                    // either because the owner let go or used up its burst.
                    if (ext_req && (!cpu_req || !burst_left)) begin
                        state      <= OWN_EXT;
                        beat_cnt   <= 4'd0;
                        last_owner <= OWNER_EXT;
                    end else if (!cpu_req) begin
                        state <= IDLE;
                    end else if (cpu_gnt && burst_left) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end

                OWN_EXT: begin
                    if (cpu_req && (!ext_req || !burst_left)) begin
                        state      <= OWN_CPU;
                        beat_cnt   <= 4'd0;
                        last_owner <= OWNER_CPU;
                    end else if (!ext_req) begin
                        state <= IDLE;
                    end else if (ext_gnt && burst_left) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives two arbiters: one with alternating ties (CPU_PRIORITY=0) backed by a
// small synchronous memory, and one with CPU priority used only for the
// tie-breaking cases. Read responses are queued when a read grant is
// expected and consumed by an independent monitor on each rvalid.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic          ext_req = 1'b0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_addr = '0;
    logic [DW-1:0] ext_wdata = '0;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_we_b;
    logic [AW-1:0] mem_addr_b;
    logic [DW-1:0] mem_write_data_b;
    logic [DW-1:0] mem_data_out_b;

    logic          p_cpu_req = 1'b0;
    logic          p_ext_req = 1'b0;
    logic          p_cpu_gnt, p_cpu_stall, p_cpu_rvalid;
    logic          p_ext_gnt, p_ext_rvalid;
    logic [DW-1:0] p_rdata;
    logic          p_mem_we_b;
    logic [AW-1:0] p_mem_addr_b;
    logic [DW-1:0] p_mem_write_data_b;
    logic [DW-1:0] p_mem_data_out_b = 8'h3C;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] ext_q[$];
    logic [DW-1:0] cpu_exp;
    logic [DW-1:0] ext_exp;

    logic [DW-1:0] mem_model [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(4), .CPU_PRIORITY(0)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .rdata(rdata),
        .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_write_data_b(mem_write_data_b),
        .mem_data_out_b(mem_data_out_b)
    );

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_BURST(4), .CPU_PRIORITY(1)
    ) dut_prio (
        .clk(clk), .rst(rst),
        .cpu_req(p_cpu_req), .cpu_we(1'b1), .cpu_addr(8'h01), .cpu_wdata(8'hC1),
        .cpu_gnt(p_cpu_gnt), .cpu_stall(p_cpu_stall), .cpu_rvalid(p_cpu_rvalid),
        .ext_req(p_ext_req), .ext_we(1'b1), .ext_addr(8'h02), .ext_wdata(8'hE2),
        .ext_gnt(p_ext_gnt), .ext_rvalid(p_ext_rvalid),
        .rdata(p_rdata),
        .mem_we_b(p_mem_we_b), .mem_addr_b(p_mem_addr_b), .mem_write_data_b(p_mem_write_data_b),
        .mem_data_out_b(p_mem_data_out_b)
    );

    // Synchronous port-B memory: write on the edge, read data one cycle later.
    always @(posedge clk) begin
        if (mem_we_b) mem_model[mem_addr_b] <= mem_write_data_b;
        mem_data_out_b <= mem_model[mem_addr_b];
    end

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest queued read response.
    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                check1("cpu_rvalid_unexpected", cpu_rvalid, 0);
            end else begin
                cpu_exp = cpu_q.pop_front();
                check1("cpu_rdata", rdata, cpu_exp);
            end
        end
        if (ext_rvalid === 1'b1) begin
            if (ext_q.size() == 0) begin
                check1("ext_rvalid_unexpected", ext_rvalid, 0);
            end else begin
                ext_exp = ext_q.pop_front();
                check1("ext_rdata", rdata, ext_exp);
            end
        end
    end

    task automatic applyStimulus(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                                 input logic er, input logic ew, input logic [7:0] ea, input logic [7:0] ed);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    endtask

    task automatic checkOutput(input string name, input logic eg_c, input logic eg_e);
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        @(negedge clk);
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (eg_c) begin
            e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata;
        end else if (eg_e) begin
            e_we = ext_we; e_addr = ext_addr; e_wd = ext_wdata;
        end
        check1({name, ":cpu_gnt"}, cpu_gnt, eg_c);
        check1({name, ":ext_gnt"}, ext_gnt, eg_e);
        check1({name, ":cpu_stall"}, cpu_stall, cpu_req & ~eg_c);
        check1({name, ":mem_we_b"}, mem_we_b, e_we);
        check1({name, ":mem_addr_b"}, mem_addr_b, e_addr);
        check1({name, ":mem_wdata_b"}, mem_write_data_b, e_wd);
    endtask

    task automatic step(input string name,
                        input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic er, input logic ew, input logic [7:0] ea, input logic [7:0] ed,
                        input logic eg_c, input logic eg_e, input int cpu_rd, input int ext_rd);
        applyStimulus(cr, cw, ca, cd, er, ew, ea, ed);
        checkOutput(name, eg_c, eg_e);
        if (cpu_rd >= 0) cpu_q.push_back(8'(cpu_rd));
        if (ext_rd >= 0) ext_q.push_back(8'(ext_rd));
    endtask

    task automatic pStep(input string name, input logic cr, input logic er, input logic eg_c, input logic eg_e);
        @(posedge clk);
        #1;
        p_cpu_req = cr;
        p_ext_req = er;
        @(negedge clk);
        check1({name, ":cpu_gnt"}, p_cpu_gnt, eg_c);
        check1({name, ":ext_gnt"}, p_ext_gnt, eg_e);
        check1({name, ":cpu_stall"}, p_cpu_stall, cr & ~eg_c);
        check1({name, ":mem_we_b"}, p_mem_we_b, eg_c | eg_e);
        check1({name, ":mem_addr_b"}, p_mem_addr_b, eg_c ? 8'h01 : (eg_e ? 8'h02 : 8'h00));
        check1({name, ":mem_wdata_b"}, p_mem_write_data_b, eg_c ? 8'hC1 : (eg_e ? 8'hE2 : 8'h00));
        check1({name, ":rvalid"}, {p_cpu_rvalid, p_ext_rvalid}, 0);
    endtask

    initial begin
        string pattern;
        int    idx;
        byte   c;

        // Reset held with a CPU request pending: nothing granted, CPU stalled.
        cpu_req = 1'b1;
        #12;
        check1("rst:cpu_gnt", cpu_gnt, 0);
        check1("rst:ext_gnt", ext_gnt, 0);
        check1("rst:cpu_stall", cpu_stall, 1);
        check1("rst:cpu_rvalid", cpu_rvalid, 0);
        check1("rst:ext_rvalid", ext_rvalid, 0);
        check1("rst:mem_we_b", mem_we_b, 0);
        check1("rst:mem_addr_b", mem_addr_b, 0);
        check1("rst:mem_wdata_b", mem_write_data_b, 0);
        check1("rst:p_rdata", p_rdata, 8'h3C);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        rst = 1'b0;

        // Simultaneous first requests: CPU first, then a direct handover.
        step("first_idle",   1, 1, 8'h10, 8'hA5, 1, 1, 8'h30, 8'h5A, 0, 0, -1, -1);
        step("first_cpu_wr", 1, 1, 8'h10, 8'hA5, 1, 1, 8'h30, 8'h5A, 1, 0, -1, -1);
        step("cpu_drop",     0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5A, 0, 0, -1, -1);
        step("ext_wr",       0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h5A, 0, 1, -1, -1);
        step("ext_drop",     0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // Read back both locations.
        step("rd_idle",      1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);
        step("cpu_rd",       1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA5, -1);
        step("rd_handoff",   0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 0, -1, -1);
        step("ext_rd",       0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00, 0, 1, -1, 8'h5A);
        step("rd_done",      0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // Unlimited burst with EXT idle: 8 writes then 8 reads, no gaps.
        step("wr_idle", 1, 1, 8'h00, 8'h40, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);
        for (int i = 0; i < 8; i++)
            step("wr_burst", 1, 1, 8'(i), 8'(8'h40 + i), 0, 0, 8'h00, 8'h00, 1, 0, -1, -1);
        for (int i = 0; i < 8; i++)
            step("rd_burst", 1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40 + i, -1);
        step("burst_done", 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // Tie after CPU ownership goes to EXT.
        step("alt_idle",   1, 1, 8'h50, 8'h77, 1, 1, 8'h51, 8'h88, 0, 0, -1, -1);
        step("alt_ext",    1, 1, 8'h50, 8'h77, 1, 1, 8'h51, 8'h88, 0, 1, -1, -1);
        step("alt_switch", 1, 1, 8'h50, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);
        step("alt_cpu",    1, 1, 8'h50, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0, -1, -1);
        step("alt_done",   0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // Burst limit: 10 CPU reads against continuous EXT reads.
        pattern = "CCCCDEEEEDCCCCDEEEEDCC";
        idx = 0;
        step("lim_start", 1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);
        for (int k = 0; k < 22; k++) begin
            c = pattern[k];
            step("lim", 1, 0, 8'(idx % 8), 8'h00, 1, 0, 8'h30, 8'h00,
                 c == "C", c == "E",
                 (c == "C") ? (8'h40 + idx % 8) : -1,
                 (c == "E") ? 8'h5A : -1);
            if (c == "C") idx++;
        end
        step("lim_end", 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // Reset right after a read grant: the pending rvalid is dropped.
        step("rrd_idle", 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);
        step("rrd_gnt",  1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, -1, -1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("rst_mid:cpu_gnt", cpu_gnt, 0);
        check1("rst_mid:cpu_rvalid", cpu_rvalid, 0);
        check1("rst_mid:cpu_stall", cpu_stall, 1);
        check1("rst_mid:mem_we_b", mem_we_b, 0);
        check1("rst_mid:mem_addr_b", mem_addr_b, 0);
        check1("rst_mid:mem_wdata_b", mem_write_data_b, 0);
        @(negedge clk);
        check1("rst_mid:rvalid_dropped", cpu_rvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rearb_idle", 0, 0);
        step("rearb_gnt",  1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA5, -1);
        step("rearb_done", 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, -1, -1);

        // CPU_PRIORITY=1 instance: CPU wins ties whoever owned last.
        pStep("p_ext_idle",  0, 1, 0, 0);
        pStep("p_ext_gnt",   0, 1, 0, 1);
        pStep("p_ext_done",  0, 0, 0, 0);
        pStep("p_tie_idle",  1, 1, 0, 0);
        pStep("p_tie_cpu",   1, 1, 1, 0);
        pStep("p_tie_done",  0, 0, 0, 0);
        pStep("p_tie2_idle", 1, 1, 0, 0);
        pStep("p_tie2_cpu",  1, 1, 1, 0);
        pStep("p_done",      0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check1("cpu_q_drained", cpu_q.size(), 0);
        check1("ext_q_drained", ext_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
